time_display_scan: RTL and testbench
====================================

Name: time_display_scan

Overview:
- Reads the BCD time produced by the clock counter (hours, minutes, seconds, pm) and drives the 3-digit multiplexed common-anode 7-segment display.
- Shows one field per page: a label digit plus two BCD digits. page_next rotates Hours → Minutes → Seconds.
- Snapshots the time once per scan frame so the digits are mutually consistent. Supports leading-zero blanking, a pm indicator and blink.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot (≥ BLANK_CYCLES+2).
- BLANK_CYCLES, 8: cycles at the start of each slot with all anodes off (anti-ghosting).
- BLINK_HALF, 25000000: cycles per blink half-period.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pm  in  1  pm flag from clock counter
- hh  in  8  hours BCD {tens,units}, 01..12
- mm  in  8  minutes BCD, 00..59
- ss  in  8  seconds BCD, 00..59
- page_next  in  1  single-cycle pulse (debounced upstream), advance page
- blink_en  in  1  level; blink the value digits
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
- an  out  3  digit enables, active-low; an[2]=label, an[1]=tens, an[0]=units
- page  out  2  current page: 0=H, 1=M, 2=S

Behaviour:
- Reset (synchronous, wins over all inputs):
  - seg=8'hFF, an=3'b111, page=0.
  - prescaler=0, digit index=0, blink counter=0, blink phase=on.
  - snapshot hh/mm/ss=0, pm=0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. On wrap, digit index advances 0→1→2→0.
- Snapshot: registers hh, mm, ss and pm on the prescaler wrap where the digit index goes 2→0. Input changes at any other time do not affect the displayed value until the next frame.
- Page FSM (states H, M, S):
  - page_next high advances H→M→S→H on that edge.
  - Invalid page value 3 goes to H.
  - The page output updates the same edge page_next is sampled.
- Blink counter: counts 0..BLINK_HALF-1. On wrap it toggles the blink phase. It free-runs regardless of blink_en.
- Output registers update every cycle, one cycle after the internal state:
  - If prescaler < BLANK_CYCLES: an=111, seg=FF.
  - Otherwise an = one-hot-low of the digit index, and seg is selected as below.
- Digit 2 (label): H=8'h89, M=8'hAB ('n'), S=8'h92.
- Digit 1: tens nibble of the page field.
  - Blank (FF) when page=H and tens=0.
- Digit 0: units nibble of the page field.
  - dp (bit7) cleared when snapshot pm=1, on every page.
- BCD decode (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Nibble >9 shows '-' (BF); dp rule still applies on digit 0.
- Blink: when blink_en=1 and blink phase=off, digits 1 and 0 output FF, dp included. The label digit is unaffected.
- Simultaneous events:
  - page_next on the snapshot edge: both take effect.
  - page_next during a blank interval: page changes and is visible when the anodes re-enable.
- Reset mid-slot: everything returns to reset values. The first digit 0 output appears BLANK_CYCLES+1 cycles after reset deasserts.

Test Plan:
- SCAN_DIV=4, BLANK_CYCLES=1, reset 3 cycles, then release → during reset seg=FF, an=111. After release an sequence per slot: 111, 110×3, 111, 101×3, 111, 011×3. Digit 2 seg=89, digit 1 FF (leading-zero blank), digit 0 C0.
- hh=8'h12, mm=8'h34, ss=8'h56, pm=1, wait one full frame → digit1=F9, digit0=24 (A4 with dp cleared), digit2=89.
- page_next pulse ×2 → page 0→1→2. S page shows label 92, digit1=92, digit0=02 (82 with dp, pm=1). A third pulse returns page to 0.
- Change ss from 8'h56 to 8'h57 mid-frame → digits unchanged until the next 2→0 wrap, then digit0 shows F8/78 with pm.
- ss=8'h5A on S page → digit0=BF (3F if pm=1).
- BLINK_HALF=6, blink_en=1 → value digits alternate between normal and FF every 6 cycles while the label digit is constant. Reset asserted during the off phase restores the on phase.

Source files
------------

// File: rtl/time_display_scan.sv
// time_display_scan
//
// Purpose:
//   Drives a 3-digit multiplexed common-anode 7-segment display from the
//   BCD time of the clock counter. One field is shown per page as a label
//   digit plus two BCD digits. The time is snapshotted once per scan frame
//   so all three digits come from the same instant. Leading-zero blanking
//   on hours, a pm indicator (dp on the units digit) and blinking of the
//   value digits are supported.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   pm         in   pm flag from the clock counter
//   hh         in   hours BCD {tens,units}, 01..12
//   mm         in   minutes BCD, 00..59
//   ss         in   seconds BCD, 00..59
//   page_next  in   single-cycle pulse, advance page H -> M -> S -> H
//   blink_en   in   level, blink the value digits
//   seg        out  {dp,g,f,e,d,c,b,a}, active-low
//   an         out  digit enables, active-low; an[2]=label, an[1]=tens, an[0]=units
//   page       out  current page: 0=H, 1=M, 2=S
//
// Parameters:
//   SCAN_DIV      clock cycles per digit slot (>= BLANK_CYCLES+2)
//   BLANK_CYCLES  cycles at the start of each slot with all anodes off
//   BLINK_HALF    cycles per blink half-period

module time_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 8,
  parameter int BLINK_HALF   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pm,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       page_next,
  input  logic       blink_en,
  output logic [7:0] seg,
  output logic [2:0] an,
  output logic [1:0] page
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] LABEL_H   = 8'h89;
  localparam logic [7:0] LABEL_M   = 8'hAB;
  localparam logic [7:0] LABEL_S   = 8'h92;

  typedef enum logic [1:0] {
    PAGE_H = 2'd0,
    PAGE_M = 2'd1,
    PAGE_S = 2'd2
  } page_t;

  // Internal state
  logic [PW-1:0] presc_reg;
  logic [1:0]    digit_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_on_reg;
  logic [7:0]    snap_hh_reg;
  logic [7:0]    snap_mm_reg;
  logic [7:0]    snap_ss_reg;
  logic          snap_pm_reg;
  page_t         page_reg;

  // Output registers
  logic [7:0]    seg_reg;
  logic [2:0]    an_reg;

  // Combinational next values for the output registers
  logic [7:0]    seg_next;
  logic [2:0]    an_next;
  logic [7:0]    field;
  logic [7:0]    label;
  logic          slot_wrap;
  logic          frame_wrap;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign slot_wrap  = (presc_reg == SCAN_LAST);
  // A new frame begins when the label slot ends; the snapshot is taken then
  // so the units/tens/label digits of one frame always agree.
  assign frame_wrap = slot_wrap && (digit_reg >= 2'd2);

  always_comb begin
    field = snap_hh_reg;
    label = LABEL_H;
    case (page_reg)
      PAGE_M: begin
        field = snap_mm_reg;
        label = LABEL_M;
      end
      PAGE_S: begin
        field = snap_ss_reg;
        label = LABEL_S;
      end
      default: begin
        field = snap_hh_reg;
        label = LABEL_H;
      end
    endcase

    seg_next = SEG_OFF;
    an_next  = 3'b111;
    if (presc_reg >= BLANK_LIM) begin
      case (digit_reg)
        2'd0: begin
          an_next  = 3'b110;
          seg_next = bcd_to_seg(field[3:0]);
          if (snap_pm_reg) seg_next[7] = 1'b0;
        end
        2'd1: begin
          an_next = 3'b101;
          if (page_reg == PAGE_H && field[7:4] == 4'd0)
            seg_next = SEG_OFF;
          else
            seg_next = bcd_to_seg(field[7:4]);
        end
        2'd2: begin
          an_next  = 3'b011;
          seg_next = label;
        end
        default: begin
          an_next  = 3'b111;
          seg_next = SEG_OFF;
        end
      endcase
      // Blink darkens only the value digits; the label stays lit.
      if (blink_en && !blink_on_reg && digit_reg != 2'd2)
        seg_next = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg     <= '0;
      digit_reg     <= 2'd0;
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
      snap_hh_reg   <= 8'h00;
      snap_mm_reg   <= 8'h00;
      snap_ss_reg   <= 8'h00;
      snap_pm_reg   <= 1'b0;
      page_reg      <= PAGE_H;
      seg_reg       <= SEG_OFF;
      an_reg        <= 3'b111;
    end else begin
      // Scan prescaler and digit index
      if (slot_wrap) begin
        presc_reg <= '0;
        digit_reg <= (digit_reg >= 2'd2) ? 2'd0 : digit_reg + 2'd1;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end

      if (frame_wrap) begin
        snap_hh_reg <= hh;
        snap_mm_reg <= mm;
        snap_ss_reg <= ss;
        snap_pm_reg <= pm;
      end

      // Blink phase free-runs so enabling blink never restarts its timing
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= ~blink_on_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end

      // Page FSM
      case (page_reg)
        PAGE_H:  if (page_next) page_reg <= PAGE_M;
        PAGE_M:  if (page_next) page_reg <= PAGE_S;
        PAGE_S:  if (page_next) page_reg <= PAGE_H;
        default: page_reg <= PAGE_H;
      endcase

      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign seg  = seg_reg;
  assign an   = an_reg;
  assign page = page_reg;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed testbench for time_display_scan with a short scan slot
// (SCAN_DIV=4, BLANK_CYCLES=1) and a short blink period (BLINK_HALF=6).
module tb_time_display_scan;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int BLINK_HALF   = 6;
  localparam int FRAME_WAIT   = 26;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pm = 1'b0;
  logic [7:0] hh = 8'h00;
  logic [7:0] mm = 8'h00;
  logic [7:0] ss = 8'h00;
  logic       page_next = 1'b0;
  logic       blink_en = 1'b0;
  logic [7:0] seg;
  logic [2:0] an;
  logic [1:0] page;

  int n_checks = 0;
  int n_fails  = 0;

  time_display_scan #(
    .SCAN_DIV(SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .BLINK_HALF(BLINK_HALF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pm(pm),
    .hh(hh),
    .mm(mm),
    .ss(ss),
    .page_next(page_next),
    .blink_en(blink_en),
    .seg(seg),
    .an(an),
    .page(page)
  );

  always #5 clk = ~clk;

  // Blink phase reference: m_on is the phase state, m_out_on the phase the
  // output stage used for the value currently on seg.
  int m_cnt = 0;
  bit m_on = 1'b1;
  bit m_out_on = 1'b1;
  always @(posedge clk) begin
    m_out_on <= m_on;
    if (reset) begin
      m_cnt <= 0;
      m_on  <= 1'b1;
    end else if (m_cnt == BLINK_HALF - 1) begin
      m_cnt <= 0;
      m_on  <= !m_on;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait until the anodes show the given pattern (sampled at negedge).
  task automatic wait_an(input logic [2:0] target);
    for (int i = 0; i < 40; i++) begin
      if (an === target) return;
      @(negedge clk);
    end
    n_checks++;
    n_fails++;
    $display("FAIL wait_an timeout: an=%b required=%b", an, target);
  endtask

  task automatic pulse_page();
    page_next = 1'b1;
    @(negedge clk);
    page_next = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] exp_an  [12] = '{3'b111, 3'b110, 3'b110, 3'b110,
                                 3'b111, 3'b101, 3'b101, 3'b101,
                                 3'b111, 3'b011, 3'b011, 3'b011};
    logic [7:0] exp_seg [12] = '{8'hFF, 8'hC0, 8'hC0, 8'hC0,
                                 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                 8'hFF, 8'h89, 8'h89, 8'h89};
    reset = 1'b1;
    step(3);
    n_checks++;
    if (seg !== 8'hFF) begin n_fails++; $display("FAIL reset_seg: seg=%h required=ff", seg); end
    n_checks++;
    if (an !== 3'b111) begin n_fails++; $display("FAIL reset_an: an=%b required=111", an); end
    n_checks++;
    if (page !== 2'd0) begin n_fails++; $display("FAIL reset_page: page=%0d required=0", page); end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (an !== exp_an[i] || seg !== exp_seg[i]) begin
        n_fails++;
        $display("FAIL first_frame[%0d]: an=%b seg=%h required an=%b seg=%h",
                 i, an, seg, exp_an[i], exp_seg[i]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_time();
    hh = 8'h12; mm = 8'h34; ss = 8'h56; pm = 1'b1;
    step(FRAME_WAIT);
    wait_an(3'b110);
    n_checks++;
    if (seg !== 8'h24) begin n_fails++; $display("FAIL h_units: seg=%h required=24", seg); end
    wait_an(3'b101);
    n_checks++;
    if (seg !== 8'hF9) begin n_fails++; $display("FAIL h_tens: seg=%h required=f9", seg); end
    wait_an(3'b011);
    n_checks++;
    if (seg !== 8'h89) begin n_fails++; $display("FAIL h_label: seg=%h required=89", seg); end
    $display("test_time done");
  endtask

  task automatic test_pages();
    pulse_page();
    n_checks++;
    if (page !== 2'd1) begin n_fails++; $display("FAIL page_to_m: page=%0d required=1", page); end
    step(FRAME_WAIT);
    wait_an(3'b110);
    n_checks++;
    if (seg !== 8'h19) begin n_fails++; $display("FAIL m_units: seg=%h required=19", seg); end
    wait_an(3'b101);
    n_checks++;
    if (seg !== 8'hB0) begin n_fails++; $display("FAIL m_tens: seg=%h required=b0", seg); end
    wait_an(3'b011);
    n_checks++;
    if (seg !== 8'hAB) begin n_fails++; $display("FAIL m_label: seg=%h required=ab", seg); end

    pulse_page();
    n_checks++;
    if (page !== 2'd2) begin n_fails++; $display("FAIL page_to_s: page=%0d required=2", page); end
    step(FRAME_WAIT);
    wait_an(3'b110);
    n_checks++;
    if (seg !== 8'h02) begin n_fails++; $display("FAIL s_units: seg=%h required=02", seg); end
    wait_an(3'b101);
    n_checks++;
    if (seg !== 8'h92) begin n_fails++; $display("FAIL s_tens: seg=%h required=92", seg); end
    wait_an(3'b011);
    n_checks++;
    if (seg !== 8'h92) begin n_fails++; $display("FAIL s_label: seg=%h required=92", seg); end
    $display("test_pages done");
  endtask

  task automatic test_snapshot();
    wait_an(3'b011);
    wait_an(3'b110);
    ss = 8'h57;
    @(negedge clk);
    n_checks++;
    if (an !== 3'b110 || seg !== 8'h02) begin
      n_fails++;
      $display("FAIL snap_hold_units: an=%b seg=%h required an=110 seg=02", an, seg);
    end
    wait_an(3'b101);
    n_checks++;
    if (seg !== 8'h92) begin n_fails++; $display("FAIL snap_hold_tens: seg=%h required=92", seg); end
    wait_an(3'b011);
    wait_an(3'b110);
    n_checks++;
    if (seg !== 8'h78) begin n_fails++; $display("FAIL snap_new_units: seg=%h required=78", seg); end
    $display("test_snapshot done");
  endtask

  task automatic test_invalid();
    ss = 8'h5A;
    step(FRAME_WAIT);
    wait_an(3'b110);
    n_checks++;
    if (seg !== 8'h3F) begin n_fails++; $display("FAIL dash_pm: seg=%h required=3f", seg); end
    pm = 1'b0;
    step(FRAME_WAIT);
    wait_an(3'b110);
    n_checks++;
    if (seg !== 8'hBF) begin n_fails++; $display("FAIL dash_nopm: seg=%h required=bf", seg); end
    // Zero tens is only blanked on the hours page
    ss = 8'h07;
    step(FRAME_WAIT);
    wait_an(3'b101);
    n_checks++;
    if (seg !== 8'hC0) begin n_fails++; $display("FAIL s_zero_tens: seg=%h required=c0", seg); end
    $display("test_invalid done");
  endtask

  task automatic test_back_to_back();
    // Page advance during the blank interval
    wait_an(3'b011);
    wait_an(3'b111);
    pulse_page();
    n_checks++;
    if (page !== 2'd0) begin n_fails++; $display("FAIL page_wrap_h: page=%0d required=0", page); end
    hh = 8'h09;
    step(FRAME_WAIT);
    wait_an(3'b101);
    n_checks++;
    if (seg !== 8'hFF) begin n_fails++; $display("FAIL h_lead_blank: seg=%h required=ff", seg); end
    wait_an(3'b011);
    n_checks++;
    if (seg !== 8'h89) begin n_fails++; $display("FAIL h_label2: seg=%h required=89", seg); end
    wait_an(3'b110);
    n_checks++;
    if (seg !== 8'h90) begin n_fails++; $display("FAIL h_units9: seg=%h required=90", seg); end
    $display("test_back_to_back done");
  endtask

  task automatic test_blink();
    logic [7:0] exp;
    bit saw_on  = 1'b0;
    bit saw_off = 1'b0;
    bit got_off = 1'b0;
    hh = 8'h12; pm = 1'b1;
    step(FRAME_WAIT);
    blink_en = 1'b1;
    step(1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      case (an)
        3'b111:  exp = 8'hFF;
        3'b011:  exp = 8'h89;
        3'b101:  exp = m_out_on ? 8'hF9 : 8'hFF;
        3'b110:  exp = m_out_on ? 8'h24 : 8'hFF;
        default: exp = 8'h00;
      endcase
      if (an == 3'b101 || an == 3'b110) begin
        if (m_out_on) saw_on = 1'b1; else saw_off = 1'b1;
      end
      n_checks++;
      if (seg !== exp) begin
        n_fails++;
        $display("FAIL blink[%0d]: an=%b seg=%h required=%h", i, an, seg, exp);
      end
    end
    n_checks++;
    if (!(saw_on && saw_off)) begin
      n_fails++;
      $display("FAIL blink_phases: saw_on=%0d saw_off=%0d required both 1", saw_on, saw_off);
    end
    // Reset during the off phase restores the on phase
    for (int i = 0; i < 20 && !got_off; i++) begin
      if (!m_on) got_off = 1'b1; else @(negedge clk);
    end
    n_checks++;
    if (!got_off) begin n_fails++; $display("FAIL blink_off_wait: off phase not reached"); end
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (an !== 3'b111) begin n_fails++; $display("FAIL rst_blank: an=%b required=111", an); end
    @(negedge clk);
    n_checks++;
    if (an !== 3'b110 || seg !== 8'hC0) begin
      n_fails++;
      $display("FAIL rst_blink_on: an=%b seg=%h required an=110 seg=c0", an, seg);
    end
    blink_en = 1'b0;
    $display("test_blink done");
  endtask

  initial begin
    test_reset();
    test_time();
    test_pages();
    test_snapshot();
    test_invalid();
    test_back_to_back();
    test_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
